// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and line geometry for the instruction prefetch path
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  localparam int LINE_BYTES   = 16;
  localparam int INS_PER_LINE = 4;
  localparam int INS_W        = 32;

endpackage

// File: rtl/fetch_line_align.sv
// rtl/fetch_line_align.sv - shifts a fetched line so the instruction at the word offset lands in slot 0
module fetch_line_align
  import fetch_pkg::*;
(
  input  logic [1:0]                      off_i,
  input  logic [INS_PER_LINE*INS_W-1:0]   line_i,
  output logic [INS_PER_LINE*INS_W-1:0]   data_o,
  output logic [2:0]                      ins_count_o
);

  // Shift by 32*off with zero fill; the upper slots past the line end stay empty.
  assign data_o      = line_i >> {off_i, 5'b0};
  assign ins_count_o = 3'(INS_PER_LINE) - {1'b0, off_i};

endmodule

// File: rtl/fetch_prefetch_ctrl.sv
// rtl/fetch_prefetch_ctrl.sv - line prefetch sequencer feeding the instruction FIFO burst port
module fetch_prefetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetch_en,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic [31:0]  mem_req_addr,
  input  logic         mem_rsp_valid,
  input  logic [127:0] mem_rsp_data,
  input  logic [3:0]   fifo_count,
  output logic         fifo_write_enable,
  output logic [127:0] fifo_write_data,
  output logic [31:0]  fifo_write_pc,
  output logic [2:0]   fifo_ins_count,
  output logic         fifo_flush,
  output logic         busy
);

  // A full line must still fit when the response lands.
  localparam logic [3:0] CREDIT_MAX = 4'(FIFO_DEPTH - INS_PER_LINE);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         credit_ok;
  logic         unused_pc_bits;

  assign credit_ok         = fetch_en && (fifo_count <= CREDIT_MAX);
  assign mem_req_valid     = (state_q == REQ);
  assign busy              = (state_q != IDLE);
  assign mem_req_addr      = {fetch_pc_q[31:4], 4'b0};
  assign fifo_flush        = redirect_valid;
  assign fifo_write_enable = (state_q == WAIT) && mem_rsp_valid && !redirect_valid;
  assign fifo_write_pc     = {fetch_pc_q[31:2], 2'b0};
  assign unused_pc_bits    = ^{redirect_pc[1:0], fetch_pc_q[1:0]};

  fetch_line_align u_align (
    .off_i       (fetch_pc_q[3:2]),
    .line_i      (mem_rsp_data),
    .data_o      (fifo_write_data),
    .ins_count_o (fifo_ins_count)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b0};
      // A request the memory has accepted leaves a response in flight that must be swallowed.
      unique case (state_q)
        IDLE:    state_d = IDLE;
        REQ:     state_d = mem_req_ready ? DROP : IDLE;
        WAIT:    state_d = mem_rsp_valid ? IDLE : DROP;
        DROP:    state_d = mem_rsp_valid ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: if (credit_ok) state_d = REQ;
        REQ:  if (mem_req_ready) state_d = WAIT;
        WAIT: if (mem_rsp_valid) begin
          state_d    = IDLE;
          fetch_pc_d = {fetch_pc_q[31:4] + 28'd1, 4'b0};
        end
        DROP: if (mem_rsp_valid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  rsp_only_when_expected: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rsp_valid |-> (state_q == WAIT || state_q == DROP));

endmodule

// File: tb/tb_fetch_prefetch_ctrl.sv
// tb/tb_fetch_prefetch_ctrl.sv - scoreboard bench for the prefetch sequencer
module tb_fetch_prefetch_ctrl;

  typedef struct {
    logic [31:0]  pc;
    logic [2:0]   cnt;
    logic [127:0] data;
  } wr_exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fetch_en;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic [3:0]   fifo_count;
  logic         fifo_write_enable;
  logic [127:0] fifo_write_data;
  logic [31:0]  fifo_write_pc;
  logic [2:0]   fifo_ins_count;
  logic         fifo_flush;
  logic         busy;

  wr_exp_t     wr_q[$];
  logic [31:0] req_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          hs_cnt = 0;
  int          mem_lat = 1;
  logic        hs_seen = 1'b0;
  logic [31:0] hs_addr = 32'h0;

  always #5 clk = ~clk;

  fetch_prefetch_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fetch_en          (fetch_en),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_addr      (mem_req_addr),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_data      (mem_rsp_data),
    .fifo_count        (fifo_count),
    .fifo_write_enable (fifo_write_enable),
    .fifo_write_data   (fifo_write_data),
    .fifo_write_pc     (fifo_write_pc),
    .fifo_ins_count    (fifo_ins_count),
    .fifo_flush        (fifo_flush),
    .busy              (busy)
  );

  // Memory content: each word encodes its own byte address so misalignment is visible.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] line_data(input logic [31:0] la);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = word_at(la + 32'(4*k));
    return d;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_req(input logic [31:0] pc);
    req_q.push_back({pc[31:4], 4'b0});
  endtask

  task automatic expect_line(input logic [31:0] pc);
    wr_exp_t e;
    int      n;
    n      = 4 - int'(pc[3:2]);
    e.pc   = {pc[31:2], 2'b0};
    e.cnt  = 3'(n);
    e.data = '0;
    for (int i = 0; i < 4; i++)
      if (i < n) e.data[32*i +: 32] = word_at(e.pc + 32'(4*i));
    expect_req(pc);
    wr_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_writes(input int target);
    int n = 0;
    while (wr_cnt < target && n < 60) begin
      tick();
      n++;
    end
    if (wr_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL wait_writes actual=%0d required=%0d", wr_cnt, target);
    end
    fetch_en = 1'b0;
  endtask

  task automatic wait_hs(input int prev);
    int n = 0;
    while (hs_cnt <= prev && n < 40) begin
      tick();
      n++;
    end
    if (hs_cnt <= prev) begin
      checks++;
      errors++;
      $display("FAIL wait_handshake actual=%0d required=%0d", hs_cnt, prev + 1);
    end
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!mem_rsp_valid && n < 40) begin
      tick();
      n++;
    end
    if (!mem_rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_response actual=0 required=1");
    end
  endtask

  // Monitor: request handshakes and FIFO writes are popped against the scoreboard.
  initial begin
    wr_exp_t e;
    forever begin
      @(negedge clk);
      hs_seen = mem_req_valid && mem_req_ready && rst_n;
      hs_addr = mem_req_addr;
      if (rst_n && mem_req_valid && mem_req_ready) begin
        hs_cnt++;
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req actual=%0h required=none", mem_req_addr);
        end else begin
          check("req_addr", mem_req_addr, req_q.pop_front());
        end
      end
      if (rst_n && fifo_write_enable) begin
        wr_cnt++;
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual_pc=%0h required=none", fifo_write_pc);
        end else begin
          e = wr_q.pop_front();
          check("write_pc", fifo_write_pc, e.pc);
          check("write_count", fifo_ins_count, e.cnt);
          check("write_data", fifo_write_data, e.data);
        end
      end
    end
  end

  // Memory: one response mem_lat cycles after each accepted request.
  initial begin
    int          cnt;
    logic        pend;
    logic [31:0] la;
    cnt           = 0;
    pend          = 1'b0;
    la            = 32'h0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      if (hs_seen) begin
        pend = 1'b1;
        cnt  = mem_lat;
        la   = hs_addr;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = line_data(la);
          pend          = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_req_ready  = 1'b1;
    fifo_count     = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_write_en", fifo_write_enable, 1'b0);
    check("rst_flush", fifo_flush, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_addr", mem_req_addr, 32'h0);

    // Back-to-back lines from reset.
    tick();
    expect_line(32'h0000_0000);
    expect_line(32'h0000_0010);
    rst_n    = 1'b1;
    fetch_en = 1'b1;
    wait_writes(2);

    // Redirect while idle into the middle of a line.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_010B;
    @(negedge clk);
    check("idle_redirect_flush", fifo_flush, 1'b1);
    check("idle_redirect_no_req", mem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("flush_one_cycle", fifo_flush, 1'b0);
    check("redirect_line_addr", mem_req_addr, 32'h0000_0100);
    tick();
    expect_line(32'h0000_0108);
    fetch_en = 1'b1;
    wait_writes(3);

    // Redirect while waiting on a slow response: the stale line must be dropped.
    mem_lat = 3;
    expect_req(32'h0000_0110);
    fetch_en = 1'b1;
    wait_hs(hs_cnt);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    fetch_en       = 1'b0;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("drop_busy", busy, 1'b1);
    check("drop_no_req", mem_req_valid, 1'b0);
    repeat (4) tick();
    @(negedge clk);
    check("drop_to_idle", busy, 1'b0);
    tick();
    mem_lat = 1;
    expect_line(32'h0000_0200);
    fetch_en = 1'b1;
    wait_writes(4);

    // Redirect landing in the same cycle as the response.
    expect_req(32'h0000_0210);
    fetch_en = 1'b1;
    wait_rsp();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    fetch_en       = 1'b0;
    @(negedge clk);
    check("same_cycle_no_write", fifo_write_enable, 1'b0);
    check("same_cycle_flush", fifo_flush, 1'b1);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("same_cycle_idle", busy, 1'b0);
    tick();
    expect_line(32'h0000_0300);
    fetch_en = 1'b1;
    wait_writes(5);

    // Credit: five instructions queued blocks issue, four allows it.
    fifo_count = 4'd5;
    fetch_en   = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("credit_block", mem_req_valid, 1'b0);
    end
    tick();
    fifo_count = 4'd4;
    expect_line(32'h0000_0310);
    @(posedge clk);
    @(negedge clk);
    check("credit_release", mem_req_valid, 1'b1);
    wait_writes(6);
    fifo_count = 4'd0;

    // Top of the address space wraps to zero.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF4;
    tick();
    redirect_valid = 1'b0;
    expect_line(32'hFFFF_FFF4);
    expect_line(32'h0000_0000);
    fetch_en = 1'b1;
    wait_writes(8);

    repeat (5) tick();
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    check("write_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_ctrl.md
# fetch_prefetch_ctrl

Prefetch sequencer that keeps the instruction FIFO supplied. It issues 16-byte-aligned line requests to the instruction memory/cache and aligns each 128-bit response to the current fetch PC. It then writes the response into the FIFO burst port with the correct `ins_count`, and flushes and redirects on an EX-stage mispredict. It sits between the I-memory port and the 8-deep instruction FIFO, and owns all of the FIFO's write-side and flush signals.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 8, FIFO capacity in instructions; must match the FIFO
- `clk` in 1, clock
- `rst_n` in 1, asynchronous, active-low reset
- `fetch_en` in 1, permits issuing new requests; an in-flight response still completes
- `redirect_valid` in 1, one-cycle mispredict/redirect strobe
- `redirect_pc` in 32, new fetch PC; bits [1:0] ignored
- `mem_req_valid` out 1, line request valid
- `mem_req_ready` in 1, memory accepts request
- `mem_req_addr` out 32, line address, bits [3:0] = 0
- `mem_rsp_valid` in 1, one-cycle response strobe
- `mem_rsp_data` in 128, line data; word k at [32k+31:32k]
- `fifo_count` in 4, FIFO occupancy
- `fifo_write_enable` out 1, FIFO burst write
- `fifo_write_data` out 128, aligned data; first instruction at [31:0]
- `fifo_write_pc` out 32, PC of the first instruction
- `fifo_ins_count` out 3, valid instructions in burst, 1–4
- `fifo_flush` out 1, FIFO flush
- `busy` out 1, state ≠ IDLE

## Operation
- Registers:
  - `fetch_pc[31:0]`, reset `RESET_PC`
  - state (IDLE/REQ/WAIT/DROP), reset IDLE
- `mem_req_addr = {fetch_pc[31:4], 4'b0}`.
- Credit rule: may enter REQ only if `fetch_en && fifo_count <= FIFO_DEPTH-4`. This guarantees the FIFO is not full (full is ≥ DEPTH-2) when the response is written.
- Single outstanding request.
- Alignment, with `off = fetch_pc[3:2]`:
  - `fifo_ins_count = 4 - off`
  - `fifo_write_data = mem_rsp_data >> (32*off)`, zero-filled
  - `fifo_write_pc = {fetch_pc[31:2], 2'b0}`
- After a write, `fetch_pc <= {fetch_pc[31:4] + 1, 4'b0}`, wrapping modulo 2^32.
- FSM transitions:
  - IDLE → REQ when the credit rule holds.
  - REQ: `mem_req_valid` = 1. On `mem_req_ready`, go to WAIT.
  - WAIT: on `mem_rsp_valid`, write the FIFO and go to IDLE.
  - DROP: discard the next `mem_rsp_valid` (no FIFO write), then go to IDLE.
- Redirect (highest priority, any state):
  - `fifo_flush = redirect_valid`, combinational, same cycle.
  - `fetch_pc <= {redirect_pc[31:2], 2'b0}`.
  - IDLE → IDLE.
  - REQ without handshake that cycle → IDLE. Withdrawing an unaccepted request is legal on this memory port.
  - REQ with handshake in the same cycle → DROP.
  - WAIT without `mem_rsp_valid` → DROP.
  - WAIT with `mem_rsp_valid` in the same cycle → response discarded, no write, → IDLE.
  - DROP → DROP if the response has not yet arrived; → IDLE if it arrives that cycle.
- `fifo_write_enable` is never asserted in a cycle with `redirect_valid`.
- Deasserting `fetch_en` blocks only IDLE → REQ. An asserted REQ holds until handshake or redirect.
- Responses outside WAIT/DROP are protocol errors: ignore them; assertion in simulation.

## Timing
- `mem_req_valid` and `busy` are decoded from registered state.
- `fifo_write_enable`, `fifo_write_data`, `fifo_write_pc`, `fifo_ins_count`:
  - combinational from `mem_rsp_valid` in WAIT, with zero added latency from response to FIFO write
  - registered `fetch_pc` is the only state-derived term
- Minimum loop: IDLE → REQ → WAIT → write is 3 cycles per line with a zero-latency memory.
- `fifo_count` is sampled in IDLE. The previous write is already reflected there because the write occurred in the WAIT exit cycle.
- Reset values: `mem_req_valid`=0, `fifo_write_enable`=0, `fifo_flush`=0, `busy`=0, `mem_req_addr`={RESET_PC[31:4],0}.
- Reset asserted mid-transaction returns to IDLE. The memory side is reset together with this block, so no DROP is needed after reset.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum {IDLE, REQ, WAIT, DROP}
  - `LINE_BYTES=16`, `INS_PER_LINE=4`, `INS_W=32`
- Sub-module `fetch_line_align`:
  - purely combinational
  - `off` + 128-bit line in → shifted data and `ins_count` out
  - reused later by the branch-target path
- Top: FSM, `fetch_pc` register, credit check, redirect priority.

## Test plan
- Reset, `fetch_en`=1, memory ready with 1-cycle response → first request addr 0x0; write pc=0x0, count=4; second request addr 0x10.
- Redirect to 0x0000_0108 while IDLE → flush pulse; next request addr 0x100; write pc=0x108, count=2, data[63:0]=rsp[127:64].
- Redirect in WAIT, response 3 cycles later → state DROP; stale line not written; next request uses the redirect line.
- Redirect in the same cycle as `mem_rsp_valid` → `fifo_write_enable`=0, `fifo_flush`=1; next request is the redirect line.
- `fifo_count`=5 in IDLE → no request. `fifo_count` drops to 4 → `mem_req_valid` next cycle. FIFO never overflows.
- `fetch_pc`=0xFFFF_FFF0 line written → next request addr 0x0000_0000 (wrap).
